// File: rtl/distance_filter.sv
// distance_filter
//   Moving-average filter for pulse-width distance measurements, with a
//   proximity alarm that uses hysteresis.
//   Each accepted sample goes into a DEPTH-entry ring buffer, and a running
//   sum is updated incrementally. Once DEPTH samples are held, every new
//   sample produces a floor mean two cycles after its strobe.
//
// Ports
//   clk          : single clock; all logic runs on its rising edge
//   reset        : synchronous active-low reset
//   distance     : raw 16-bit measurement, qualified by sample_valid
//   sample_valid : one-cycle strobe; distance is valid in the same cycle
//   flush        : synchronous clear of history and of in-flight results
//   avg_distance : filtered (mean) distance
//   avg_valid    : one-cycle strobe marking a new avg_distance
//   filled       : high once DEPTH samples are held since reset/flush
//   near         : proximity alarm; sets below NEAR_THRESH and releases at
//                  NEAR_THRESH + NEAR_HYST or above
module distance_filter #(
   parameter int          DEPTH       = 8,
   parameter logic [15:0] NEAR_THRESH = 16'd100,
   parameter logic [15:0] NEAR_HYST   = 16'd10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] distance,
   input  logic        sample_valid,
   input  logic        flush,
   output logic [15:0] avg_distance,
   output logic        avg_valid,
   output logic        filled,
   output logic        near
);

   localparam int DATA_W = 16;
   localparam int SH     = $clog2(DEPTH);
   localparam int SUM_W  = DATA_W + SH;
   localparam int PTR_W  = SH;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(DEPTH - 1);
   // Computed one bit wider so that the release level cannot wrap.
   localparam logic [DATA_W:0]  NEAR_REL  = {1'b0, NEAR_THRESH} + {1'b0, NEAR_HYST};

   // The floor mean of the window. DEPTH is a power of two, so the divide
   // reduces to dropping the low SH bits of the sum.
   function automatic logic [DATA_W-1:0] floor_mean(input logic [SUM_W-1:0] s);
      return s[SUM_W-1:SH];
   endfunction

   logic [DATA_W-1:0] ring [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic [SUM_W-1:0]  sum_p1;
   logic              vld_p1;
   logic [DATA_W-1:0] mean_p1;
   logic              accept;

   assign accept  = sample_valid && !flush;
   assign mean_p1 = floor_mean(sum_p1);

   // ---- stage 1: ring write, running sum, fill count ----
   // The sum cannot underflow: the entry being replaced is always one of
   // the addends already in the sum (a cleared slot holds zero).
   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
         wr_ptr <= '0;
         count  <= '0;
         filled <= 1'b0;
         sum_p1 <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= sample_valid;
         if (sample_valid) begin
            sum_p1         <= sum_p1 + SUM_W'(distance) - SUM_W'(ring[wr_ptr]);
            ring[wr_ptr]   <= distance;
            wr_ptr         <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (count != CNT_FULL) count <= count + 1'b1;
            if (count >= CNT_PRE) filled <= 1'b1;
         end
      end
   end

   // ---- stage 2: mean register, result strobe, hysteretic alarm ----
   // A flush cancels a result that is due, but avg_distance and near keep
   // their last values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         avg_distance <= '0;
         avg_valid    <= 1'b0;
         near         <= 1'b0;
      end else if (flush) begin
         avg_valid <= 1'b0;
      end else begin
         avg_valid <= vld_p1 && filled;
         if (vld_p1 && filled) begin
            avg_distance <= mean_p1;
            if (mean_p1 < NEAR_THRESH)
               near <= 1'b1;
            else if ({1'b0, mean_p1} >= NEAR_REL)
               near <= 1'b0;
         end
      end
   end

   // accept is a named qualifier used only for readability of intent.
   logic unused_ok;
   assign unused_ok = accept;

endmodule

// File: tb/tb_distance_filter.sv
module tb_distance_filter;

   localparam int D = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] distance;
   logic        sample_valid;
   logic        flush;
   logic [15:0] avg_distance;
   logic        avg_valid;
   logic        filled;
   logic        near;

   distance_filter #(.DEPTH(D), .NEAR_THRESH(16'd100), .NEAR_HYST(16'd10)) dut (
      .clk(clk), .reset(reset), .distance(distance), .sample_valid(sample_valid),
      .flush(flush), .avg_distance(avg_distance), .avg_valid(avg_valid),
      .filled(filled), .near(near));

   always #5 clk = ~clk;

   // ---- reference model: window of the last D accepted samples ----
   typedef struct { int due; int avg; } pend_t;
   int    hist[$];
   pend_t pend[$];
   int    cyc = 0;
   int    exp_avg = 0, exp_valid = 0, exp_filled = 0, exp_near = 0;
   int    n_chk = 0, n_fail = 0;
   int    seen_avg[$];
   int    seen_near[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic rn, input logic sv, input logic fl, input logic [15:0] d);
      pend_t e;
      int s;
      exp_valid = 0;
      if (!rn) begin
         hist.delete(); pend.delete();
         exp_avg = 0; exp_near = 0; exp_filled = 0;
      end else if (fl) begin
         hist.delete(); pend.delete();
         exp_filled = 0;
      end else begin
         if (pend.size() > 0 && pend[0].due == cyc) begin
            e = pend.pop_front();
            exp_valid = 1;
            exp_avg = e.avg;
            if (e.avg < 100) exp_near = 1;
            else if (e.avg >= 110) exp_near = 0;
         end
         if (sv) begin
            hist.push_back(int'(d));
            if (hist.size() > D) void'(hist.pop_front());
            exp_filled = (hist.size() == D) ? 1 : 0;
            if (exp_filled == 1) begin
               s = 0;
               foreach (hist[i]) s += hist[i];
               e.due = cyc + 1;
               e.avg = s / D;
               pend.push_back(e);
            end
         end
      end
   endtask

   task automatic cycle(input logic rn, input logic sv, input logic fl, input logic [15:0] d);
      reset = rn; sample_valid = sv; flush = fl; distance = d;
      @(posedge clk);
      model_edge(rn, sv, fl, d);
      cyc++;
      #1;
      chk("avg_valid", 32'(avg_valid), 32'(exp_valid));
      chk("filled", 32'(filled), 32'(exp_filled));
      chk("near", 32'(near), 32'(exp_near));
      chk("avg_distance", 32'(avg_distance), 32'(exp_avg));
      if (avg_valid === 1'b1) begin
         seen_avg.push_back(int'(avg_distance));
         seen_near.push_back(int'(near));
      end
   endtask

   task automatic send(input logic [15:0] d, input int gap);
      cycle(1'b1, 1'b1, 1'b0, d);
      for (int g = 1; g < gap; g++) cycle(1'b1, 1'b0, 1'b0, 16'($urandom));
   endtask

   int exp_seq [9] = '{200, 180, 160, 140, 120, 100, 80, 60, 40};
   int rnd_s [8];
   int rsum;

   initial begin
      reset = 1'b0; sample_valid = 1'b0; flush = 1'b0; distance = '0;

      // Reset held with sample_valid toggling: everything stays zero.
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'(i % 2), 1'b0, 16'($urandom));
      chk("reset_no_valid", 32'(seen_avg.size()), 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 16'd0);
      cycle(1'b1, 1'b0, 1'b0, 16'd0);

      // Eight samples of 200, five cycles apart.
      seen_avg.delete(); seen_near.delete();
      for (int i = 0; i < 7; i++) send(16'd200, 5);
      chk("no_valid_before_fill", 32'(seen_avg.size()), 32'd0);
      chk("not_filled_at_7", 32'(filled), 32'd0);
      send(16'd200, 5);
      chk("fill_one_valid", 32'(seen_avg.size()), 32'd1);
      if (seen_avg.size() == 1) chk("fill_avg200", 32'(seen_avg[0]), 32'd200);
      chk("filled_after_8", 32'(filled), 32'd1);
      chk("near_at_200", 32'(near), 32'd0);

      // Eight samples of 40: the average walks down; near sets at 80.
      seen_avg.delete(); seen_near.delete();
      for (int i = 0; i < 8; i++) send(16'd40, 5);
      chk("down_count", 32'(seen_avg.size()), 32'd8);
      if (seen_avg.size() == 8)
         for (int i = 0; i < 8; i++) begin
            chk("down_avg", 32'(seen_avg[i]), 32'(exp_seq[i+1]));
            chk("down_near", 32'(seen_near[i]), (i >= 5) ? 32'd1 : 32'd0);
         end

      // Hysteresis: 105 sits inside the band, so near holds.
      seen_avg.delete(); seen_near.delete();
      for (int i = 0; i < 8; i++) send(16'd105, 3);
      chk("band_count", 32'(seen_avg.size()), 32'd8);
      if (seen_avg.size() == 8) chk("band_last_avg", 32'(seen_avg[7]), 32'd105);
      foreach (seen_near[i]) chk("band_near_held", 32'(seen_near[i]), 32'd1);

      // Then 110: near releases only when the average first reaches 110.
      seen_avg.delete(); seen_near.delete();
      for (int i = 0; i < 8; i++) send(16'd110, 3);
      chk("rel_count", 32'(seen_avg.size()), 32'd8);
      if (seen_avg.size() == 8) begin
         chk("rel_avg7", 32'(seen_avg[6]), 32'd109);
         chk("rel_near7", 32'(seen_near[6]), 32'd1);
         chk("rel_avg8", 32'(seen_avg[7]), 32'd110);
         chk("rel_near8", 32'(seen_near[7]), 32'd0);
      end

      // Flush, then the 200/40 stimulus back-to-back on every cycle.
      cycle(1'b1, 1'b0, 1'b1, 16'd0);
      chk("flush_filled", 32'(filled), 32'd0);
      seen_avg.delete(); seen_near.delete();
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 16'd200);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 16'd40);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 16'd0);
      chk("b2b_count", 32'(seen_avg.size()), 32'd9);
      if (seen_avg.size() == 9)
         for (int i = 0; i < 9; i++) chk("b2b_avg", 32'(seen_avg[i]), 32'(exp_seq[i]));

      // Flush coincident with a sample mid-stream.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 16'($urandom_range(0, 300)));
      seen_avg.delete(); seen_near.delete();
      cycle(1'b1, 1'b1, 1'b1, 16'd999);
      chk("flush_coinc_filled", 32'(filled), 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 16'd0);
      cycle(1'b1, 1'b0, 1'b0, 16'd0);
      chk("flush_no_valid", 32'(seen_avg.size()), 32'd0);
      rsum = 0;
      for (int i = 0; i < 8; i++) begin
         rnd_s[i] = $urandom_range(0, 65535);
         rsum += rnd_s[i];
         cycle(1'b1, 1'b1, 1'b0, 16'(rnd_s[i]));
      end
      chk("refill_no_early", 32'(seen_avg.size()), 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 16'd0);
      chk("refill_one_valid", 32'(seen_avg.size()), 32'd1);
      if (seen_avg.size() == 1) chk("refill_mean", 32'(seen_avg[0]), 32'(rsum / 8));

      // Randomised traffic against the reference model.
      for (int i = 0; i < 600; i++) begin
         logic rn, sv, fl;
         logic [15:0] d;
         rn = ($urandom_range(0, 199) != 0);
         sv = ($urandom_range(0, 3) != 0);
         fl = ($urandom_range(0, 49) == 0);
         d  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 65535))
                                          : 16'($urandom_range(60, 150));
         cycle(rn, sv, fl, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
